// File: rtl/bist_session_ctrl.sv
// Tester-side session controller for the BIST block: pulses the BIST reset,
// holds testmode for one full LFSR sweep, samples the fault flag on its single
// valid cycle and accumulates per-run pass/fail results across NUM_RUNS runs.
module bist_session_ctrl #(
  parameter int SESSION_LEN = 16,
  parameter int NUM_RUNS    = 4,
  parameter int RST_CYCLES  = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             aborted_o,
  output logic [CNT_W-1:0] fail_count_o,
  output logic [CNT_W-1:0] first_fail_o,
  output logic             bist_rst_o,
  output logic             bist_testmode_o,
  input  logic             bist_fault_i
);

  // run_cnt must reach SESSION_LEN+1; rst_cnt must reach RST_CYCLES-1.
  localparam int RUN_W = $clog2(SESSION_LEN + 2);
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(SESSION_LEN + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUNS_LAST = CNT_W'(NUM_RUNS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_BIST,
    S_RUN,
    S_EVAL,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] run_idx_q, run_idx_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] first_fail_q, first_fail_d;
  logic             fault_q, fault_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             aborted_q, aborted_d;
  logic             bist_rst_q, bist_rst_d;
  logic             tm_q, tm_d;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(1);
  endfunction

  // Next-state and next-output logic; outputs are derived from the next state
  // so every output register changes on the same edge as the state.
  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    run_idx_d    = run_idx_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    fault_d      = fault_q;
    pass_d       = pass_q;
    aborted_d    = aborted_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d      = S_RST_BIST;
          run_idx_d    = CNT_W'(1);
          rst_cnt_d    = '0;
          fail_cnt_d   = '0;
          first_fail_d = '0;
          pass_d       = 1'b0;
          aborted_d    = 1'b0;
        end
      end
      S_RST_BIST: begin
        if (abort_i) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (rst_cnt_q == RST_LAST) begin
          state_d   = S_RUN;
          run_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      S_RUN: begin
        // Abort wins over the sample; fault is only looked at on the last RUN cycle.
        if (abort_i) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (run_cnt_q == RUN_LAST) begin
          fault_d = bist_fault_i;
          state_d = S_EVAL;
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end
      S_EVAL: begin
        if (abort_i) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else begin
          if (fault_q) begin
            fail_cnt_d = sat_inc(fail_cnt_q);
            if (first_fail_q == '0) first_fail_d = run_idx_q;
          end
          if (run_idx_q == RUNS_LAST) begin
            state_d = S_DONE;
          end else begin
            run_idx_d = run_idx_q + CNT_W'(1);
            rst_cnt_d = '0;
            state_d   = S_RST_BIST;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d == S_RST_BIST) || (state_d == S_RUN) || (state_d == S_EVAL);
    done_d     = (state_d == S_DONE);
    tm_d       = (state_d == S_RUN);
    bist_rst_d = !((state_d == S_RUN) || (state_d == S_EVAL));
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      pass_d = (fail_cnt_d == '0) && !aborted_d;
    end
  end

  // State and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      run_cnt_q    <= '0;
      rst_cnt_q    <= '0;
      run_idx_q    <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      fault_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      aborted_q    <= 1'b0;
      bist_rst_q   <= 1'b1;
      tm_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      run_idx_q    <= run_idx_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      fault_q      <= fault_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      aborted_q    <= aborted_d;
      bist_rst_q   <= bist_rst_d;
      tm_q         <= tm_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign aborted_o       = aborted_q;
  assign fail_count_o    = fail_cnt_q;
  assign first_fail_o    = first_fail_q;
  assign bist_rst_o      = bist_rst_q;
  assign bist_testmode_o = tm_q;

endmodule

// File: tb/tb_bist_session_ctrl.sv
// Directed bench for bist_session_ctrl at default parameters.
module tb_bist_session_ctrl;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          abort_i;
  logic          busy_o;
  logic          done_o;
  logic          pass_o;
  logic          aborted_o;
  logic [CW-1:0] fail_count_o;
  logic [CW-1:0] first_fail_o;
  logic          bist_rst_o;
  logic          bist_testmode_o;
  logic          bist_fault_i;

  int n_checks = 0;
  int n_pass   = 0;

  bist_session_ctrl #(
    .SESSION_LEN(16),
    .NUM_RUNS(4),
    .RST_CYCLES(2),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .abort_i(abort_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .pass_o(pass_o),
    .aborted_o(aborted_o),
    .fail_count_o(fail_count_o),
    .first_fail_o(first_fail_o),
    .bist_rst_o(bist_rst_o),
    .bist_testmode_o(bist_testmode_o),
    .bist_fault_i(bist_fault_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start and follow the request to done_o.
  // Cycle n = state after the n-th edge counted from the edge that takes start.
  // RUN of run r covers n = 3+21*(r-1)+p for p=0..17; p=17 is the sample cycle.
  // mode 0: no fault; mode 1: fault only on sample cycle of runs set in mask;
  // mode 2: fault on every p in 0..18 except the sample cycle.
  task automatic run_request(input string tag, input int mode, input logic [4:0] mask,
                             input int abort_run, input int abort_pos, input int repulse_cyc,
                             output int done_cyc, output int tm_runs, output int tm_bad);
    int   cyc;
    int   r;
    int   p;
    int   tm_len;
    logic seen;
    done_cyc = 0;
    tm_runs  = 0;
    tm_bad   = 0;
    tm_len   = 0;
    seen     = 1'b0;
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
    cyc      = 1;
    check({tag, ":busy_after_start"}, busy_o, 1);
    check({tag, ":aborted_cleared"}, aborted_o, 0);
    check({tag, ":fail_cleared"}, fail_count_o, 0);
    check({tag, ":bist_rst_in_rstbist"}, bist_rst_o, 1);
    while (!seen && cyc < 200) begin
      r = 0;
      p = -1;
      if (cyc >= 3) begin
        r = (cyc - 3) / 21 + 1;
        p = (cyc - 3) % 21;
      end
      bist_fault_i = 1'b0;
      if (r >= 1 && r <= 4) begin
        if (mode == 1) bist_fault_i = (p == 17) && mask[r];
        if (mode == 2) bist_fault_i = (p <= 18) && (p != 17);
      end
      abort_i = (r == abort_run) && (p == abort_pos);
      start_i = (cyc == repulse_cyc);
      tick();
      cyc++;
      bist_fault_i = 1'b0;
      abort_i      = 1'b0;
      start_i      = 1'b0;
      if (bist_testmode_o) tm_len++;
      else if (tm_len > 0) begin
        tm_runs++;
        if (tm_len != 18) tm_bad++;
        tm_len = 0;
      end
      if (done_o) begin
        seen     = 1'b1;
        done_cyc = cyc;
      end
    end
    if (!seen) check({tag, ":done_timeout"}, 0, 1);
  endtask

  int dc, tr, tb;
  int ndone;

  initial begin
    rst          = 1'b1;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    bist_fault_i = 1'b0;
    tick();
    tick();
    check("rst:bist_rst", bist_rst_o, 1);
    check("rst:testmode", bist_testmode_o, 0);
    check("rst:busy", busy_o, 0);
    check("rst:done", done_o, 0);
    check("rst:pass", pass_o, 0);
    check("rst:aborted", aborted_o, 0);
    check("rst:fail_count", fail_count_o, 0);
    check("rst:first_fail", first_fail_o, 0);
    rst = 1'b0;
    tick();
    tick();
    check("idle:busy", busy_o, 0);

    // 1: clean request
    run_request("t1", 0, 5'b0, 0, 0, 0, dc, tr, tb);
    check("t1:latency", dc, 85);
    check("t1:pass", pass_o, 1);
    check("t1:fail_count", fail_count_o, 0);
    check("t1:first_fail", first_fail_o, 0);
    check("t1:tm_runs", tr, 4);
    check("t1:tm_len_bad", tb, 0);
    check("t1:busy_in_done", busy_o, 0);
    check("t1:bist_rst_in_done", bist_rst_o, 1);
    tick();
    check("t1:done_one_cycle", done_o, 0);
    check("t1:pass_held", pass_o, 1);

    // 2: faults sampled in runs 2 and 4
    run_request("t2", 1, 5'b10100, 0, 0, 0, dc, tr, tb);
    check("t2:latency", dc, 85);
    check("t2:fail_count", fail_count_o, 2);
    check("t2:first_fail", first_fail_o, 2);
    check("t2:pass", pass_o, 0);
    tick();

    // 3: fault asserted everywhere except the sample cycle
    run_request("t3", 2, 5'b0, 0, 0, 0, dc, tr, tb);
    check("t3:latency", dc, 85);
    check("t3:pass", pass_o, 1);
    check("t3:fail_count", fail_count_o, 0);
    check("t3:first_fail", first_fail_o, 0);
    tick();

    // 4: run-1 fault, abort in run 3 at RUN cycle 5
    run_request("t4", 1, 5'b00010, 3, 5, 0, dc, tr, tb);
    check("t4:latency", dc, 51);
    check("t4:testmode", bist_testmode_o, 0);
    check("t4:aborted", aborted_o, 1);
    check("t4:pass", pass_o, 0);
    check("t4:fail_count", fail_count_o, 1);
    check("t4:first_fail", first_fail_o, 1);
    check("t4:tm_runs", tr, 3);
    tick();
    check("t4:aborted_held", aborted_o, 1);

    // 5: start re-pulsed while busy and in the DONE cycle
    run_request("t5", 0, 5'b0, 0, 0, 10, dc, tr, tb);
    check("t5:latency", dc, 85);
    check("t5:tm_runs", tr, 4);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("t5:no_restart_busy", busy_o, 0);
    check("t5:done_dropped", done_o, 0);
    check("t5:pass_kept", pass_o, 1);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done_o || busy_o) ndone++;
    end
    check("t5:no_queued_request", ndone, 0);

    // 6: rst during RUN of run 2
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (27) tick();
    check("t6:in_run2", bist_testmode_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6:bist_rst", bist_rst_o, 1);
    check("t6:busy", busy_o, 0);
    check("t6:testmode", bist_testmode_o, 0);
    check("t6:done", done_o, 0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done_o) ndone++;
    end
    check("t6:no_done", ndone, 0);
    run_request("t6b", 0, 5'b0, 0, 0, 0, dc, tr, tb);
    check("t6b:latency", dc, 85);
    check("t6b:pass", pass_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
